// File: rtl/bottomhalf_bus_pkg.sv
// Shared definitions for the bottom-half bus initiator.
//   - bh_state_e   : bus cycle sequencer states
//   - ADDR_OK_BIT  : address bit the target treats as "address OK"
//   - ID_*_ADDR    : identification register addresses on the target
//   - T_*_DEF      : default phase lengths in osc cycles
//   - phase_load() : counter reload value for a phase of N cycles
package bottomhalf_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_AHOLD,
      ST_SETUP,
      ST_STROBE,
      ST_RECOVER
   } bh_state_e;

   localparam int ADDR_OK_BIT = 4;

   localparam logic [7:0] ID_MAJOR_LO_ADDR = 8'hFD;
   localparam logic [7:0] ID_MAJOR_HI_ADDR = 8'hFE;
   localparam logic [7:0] ID_MINOR_ADDR    = 8'hFF;

   localparam int unsigned T_ALE_DEF     = 2;
   localparam int unsigned T_AHOLD_DEF   = 1;
   localparam int unsigned T_SETUP_DEF   = 1;
   localparam int unsigned T_PULSE_DEF   = 3;
   localparam int unsigned T_RECOVER_DEF = 1;

   // A phase of N cycles runs the down-counter from N-1 to 0.
   function automatic logic [7:0] phase_load(input int unsigned cycles);
      return 8'(cycles - 1);
   endfunction

endpackage

// File: rtl/bus_phase_timer.sv
// Loadable 8-bit down-counter timing one bus phase.
//   osc   in  clock
//   rst_n in  async active-low reset
//   load  in  load value into the counter this edge
//   value in  reload value (phase length minus one)
//   zero  out counter has reached its terminal count
module bus_phase_timer (
   input  logic       osc,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] value,
   output logic       zero
);

   logic [7:0] count;

   // Holds at zero between transactions instead of wrapping.
   always_ff @(posedge osc or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != 8'd0) begin
         count <= count - 8'd1;
      end
   end

   assign zero = (count == 8'd0);

endmodule

// File: rtl/bottomhalf_bus_initiator.sv
// Host-side initiator for the bottom-half parallel bus. Accepts one byte
// transaction over a valid/ready port and runs ALE, address hold, data
// setup, strobe and recovery phases; completion is a one-cycle rsp_valid.
//   osc, rst_n              clock, async active-low reset
//   req_valid/req_ready     request handshake
//   req_write/addr/wdata    transaction (wdata ignored for reads)
//   rsp_valid/rsp_rdata     completion pulse and read data (0 for writes)
//   bus_data_o/oe/i         bus data drive, enable and sampled value
//   bus_ale                 address latch enable
//   bus_write_n/bus_read_n  active-low strobes
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | no transaction; ready when reset has been released
// ST_ADDR    | ALE high, address driven
// ST_AHOLD   | ALE low, address still driven
// ST_SETUP   | write data driven (writes) or bus released (reads)
// ST_STROBE  | write_n or read_n low
// ST_RECOVER | strobes high; write data held, read bus released
module bottomhalf_bus_initiator
   import bottomhalf_bus_pkg::*;
#(
   parameter int unsigned T_ALE     = T_ALE_DEF,
   parameter int unsigned T_AHOLD   = T_AHOLD_DEF,
   parameter int unsigned T_SETUP   = T_SETUP_DEF,
   parameter int unsigned T_PULSE   = T_PULSE_DEF,
   parameter int unsigned T_RECOVER = T_RECOVER_DEF
) (
   input  logic       osc,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [7:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic [7:0] bus_data_o,
   output logic       bus_data_oe,
   input  logic [7:0] bus_data_i,
   output logic       bus_ale,
   output logic       bus_write_n,
   output logic       bus_read_n
);

   bh_state_e  state, state_nxt;
   logic       armed;
   logic       req_fire;
   logic       timer_load;
   logic [7:0] timer_value;
   logic       timer_zero;
   logic       cap_write, write_nxt;
   logic [7:0] cap_addr, addr_nxt;
   logic [7:0] cap_wdata, wdata_nxt;
   logic [7:0] rd_sample;
   logic       rsp_nxt;
   logic       ale_nxt, write_n_nxt, read_n_nxt, oe_nxt;
   logic [7:0] data_nxt;

   // armed keeps ready low until the first edge after reset release.
   assign req_ready = armed && (state == ST_IDLE);
   assign req_fire  = req_valid && req_ready;

   // Outputs are decoded from the next state so they can be registered
   // and still line up with the state they belong to.
   assign write_nxt = req_fire ? req_write : cap_write;
   assign addr_nxt  = req_fire ? req_addr  : cap_addr;
   assign wdata_nxt = req_fire ? req_wdata : cap_wdata;

   bus_phase_timer u_timer (
      .osc   (osc),
      .rst_n (rst_n),
      .load  (timer_load),
      .value (timer_value),
      .zero  (timer_zero)
   );

   always_ff @(posedge osc or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      timer_load  = 1'b0;
      timer_value = '0;
      rsp_nxt     = 1'b0;
      ale_nxt     = 1'b0;
      write_n_nxt = 1'b1;
      read_n_nxt  = 1'b1;
      oe_nxt      = 1'b0;
      data_nxt    = '0;

      case (state)
         ST_IDLE: begin
            if (req_fire) begin
               state_nxt   = ST_ADDR;
               timer_load  = 1'b1;
               timer_value = phase_load(T_ALE);
            end
         end
         ST_ADDR: begin
            if (timer_zero) begin
               state_nxt   = ST_AHOLD;
               timer_load  = 1'b1;
               timer_value = phase_load(T_AHOLD);
            end
         end
         ST_AHOLD: begin
            if (timer_zero) begin
               state_nxt   = ST_SETUP;
               timer_load  = 1'b1;
               timer_value = phase_load(T_SETUP);
            end
         end
         ST_SETUP: begin
            if (timer_zero) begin
               state_nxt   = ST_STROBE;
               timer_load  = 1'b1;
               timer_value = phase_load(T_PULSE);
            end
         end
         ST_STROBE: begin
            if (timer_zero) begin
               state_nxt   = ST_RECOVER;
               timer_load  = 1'b1;
               timer_value = phase_load(T_RECOVER);
            end
         end
         ST_RECOVER: begin
            if (timer_zero) begin
               state_nxt = ST_IDLE;
               rsp_nxt   = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      case (state_nxt)
         ST_ADDR: begin
            ale_nxt  = 1'b1;
            oe_nxt   = 1'b1;
            data_nxt = addr_nxt;
         end
         ST_AHOLD: begin
            oe_nxt   = 1'b1;
            data_nxt = addr_nxt;
         end
         ST_SETUP, ST_RECOVER: begin
            if (write_nxt) begin
               oe_nxt   = 1'b1;
               data_nxt = wdata_nxt;
            end
         end
         ST_STROBE: begin
            if (write_nxt) begin
               oe_nxt      = 1'b1;
               data_nxt    = wdata_nxt;
               write_n_nxt = 1'b0;
            end else begin
               read_n_nxt  = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge osc or negedge rst_n) begin
      if (!rst_n) begin
         armed       <= 1'b0;
         cap_write   <= 1'b0;
         cap_addr    <= '0;
         cap_wdata   <= '0;
         rd_sample   <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         bus_ale     <= 1'b0;
         bus_write_n <= 1'b1;
         bus_read_n  <= 1'b1;
         bus_data_oe <= 1'b0;
         bus_data_o  <= '0;
      end else begin
         armed     <= 1'b1;
         cap_write <= write_nxt;
         cap_addr  <= addr_nxt;
         cap_wdata <= wdata_nxt;
         // Capture on the edge closing the last strobe cycle while the
         // target is still driving; published only at completion.
         if (state == ST_STROBE && timer_zero && !cap_write) begin
            rd_sample <= bus_data_i;
         end
         rsp_valid <= rsp_nxt;
         if (rsp_nxt) begin
            rsp_rdata <= cap_write ? 8'h00 : rd_sample;
         end
         bus_ale     <= ale_nxt;
         bus_write_n <= write_n_nxt;
         bus_read_n  <= read_n_nxt;
         bus_data_oe <= oe_nxt;
         bus_data_o  <= data_nxt;
      end
   end

endmodule

// File: tb/tb_bottomhalf_bus_initiator.sv
// Bench for bottomhalf_bus_initiator: one instance with default timing and
// one with every phase set to 1, each attached to a small target memory.
module tb_bottomhalf_bus_initiator;

   localparam int NI = 2;
   localparam int TA [NI] = '{2, 1};
   localparam int TH [NI] = '{1, 1};
   localparam int TS [NI] = '{1, 1};
   localparam int TP [NI] = '{3, 1};
   localparam int TR [NI] = '{1, 1};

   logic       osc   = 1'b0;
   logic       rst_n = 1'b1;
   logic       req_valid   [NI];
   logic       req_ready   [NI];
   logic       req_write   [NI];
   logic [7:0] req_addr    [NI];
   logic [7:0] req_wdata   [NI];
   logic       rsp_valid   [NI];
   logic [7:0] rsp_rdata   [NI];
   logic [7:0] bus_data_o  [NI];
   logic       bus_data_oe [NI];
   logic [7:0] bus_data_i  [NI];
   logic       bus_ale     [NI];
   logic       bus_write_n [NI];
   logic       bus_read_n  [NI];

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [7:0] mm [NI][256];
   bit         active   [NI];
   int         off      [NI];
   bit         armed    [NI];
   bit         rsp_flag [NI];
   logic [7:0] rsp_rd   [NI];
   bit         hs_now   [NI];
   bit         cur_w    [NI];
   logic [7:0] cur_a    [NI];
   logic [7:0] cur_d    [NI];
   int         cyc = 0;

   // observation logs
   int         hs_cyc  [NI][$];
   int         rsp_cyc [NI][$];
   logic [7:0] rsp_dat [NI][$];
   int         ale_cnt [NI];
   int         wn_cnt  [NI];
   int         rn_cnt  [NI];

   initial forever #5 osc = ~osc;

   bottomhalf_bus_initiator dut0 (
      .osc(osc), .rst_n(rst_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
      .bus_data_o(bus_data_o[0]), .bus_data_oe(bus_data_oe[0]), .bus_data_i(bus_data_i[0]),
      .bus_ale(bus_ale[0]), .bus_write_n(bus_write_n[0]), .bus_read_n(bus_read_n[0])
   );

   bottomhalf_bus_initiator #(
      .T_ALE(1), .T_AHOLD(1), .T_SETUP(1), .T_PULSE(1), .T_RECOVER(1)
   ) dut1 (
      .osc(osc), .rst_n(rst_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
      .bus_data_o(bus_data_o[1]), .bus_data_oe(bus_data_oe[1]), .bus_data_i(bus_data_i[1]),
      .bus_ale(bus_ale[1]), .bus_write_n(bus_write_n[1]), .bus_read_n(bus_read_n[1])
   );

   // Bus targets: latch address on ALE fall, data on write_n rise, drive
   // memory contents while read_n is low. Addresses without the OK bit are
   // ignored and the bus floats to zero.
   for (genvar g = 0; g < NI; g++) begin : tgt
      logic [7:0] tmem [256];
      logic [7:0] lat = 8'h00;
      initial begin
         #1;
         for (int a = 0; a < 256; a++) tmem[a] = mm[g][a];
      end
      initial forever begin
         @(negedge bus_ale[g]);
         lat = bus_data_o[g];
      end
      initial forever begin
         @(posedge bus_write_n[g]);
         if (rst_n && lat[4]) tmem[lat] = bus_data_o[g];
      end
      always_comb bus_data_i[g] = (!bus_read_n[g] && lat[4]) ? tmem[lat] : 8'h00;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // Transaction-level model: a transaction is a window of L cycles after
   // its handshake edge, with the completion pulse in the cycle after it.
   initial forever begin
      @(posedge osc or negedge rst_n);
      if (!rst_n) begin
         for (int i = 0; i < NI; i++) begin
            active[i] = 0; armed[i] = 0; rsp_flag[i] = 0; rsp_rd[i] = 8'h00; hs_now[i] = 0;
         end
      end else begin
         cyc++;
         for (int i = 0; i < NI; i++) begin
            bit hs;
            int lat_cyc;
            lat_cyc = TA[i] + TH[i] + TS[i] + TP[i] + TR[i];
            hs = (req_valid[i] === 1'b1) && armed[i] && !active[i];
            rsp_flag[i] = 0;
            hs_now[i] = 0;
            if (active[i]) begin
               off[i]++;
               if (off[i] == lat_cyc) begin
                  active[i] = 0;
                  rsp_flag[i] = 1;
                  if (cur_w[i]) begin
                     rsp_rd[i] = 8'h00;
                     if (cur_a[i][4]) mm[i][cur_a[i]] = cur_d[i];
                  end else begin
                     rsp_rd[i] = cur_a[i][4] ? mm[i][cur_a[i]] : 8'h00;
                  end
               end
            end
            if (hs) begin
               active[i] = 1; off[i] = 0;
               cur_w[i] = req_write[i]; cur_a[i] = req_addr[i]; cur_d[i] = req_wdata[i];
               hs_now[i] = 1;
               hs_cyc[i].push_back(cyc);
            end
            armed[i] = 1;
         end
      end
   end

   // Compare every DUT output against the model on every falling edge.
   initial forever begin
      @(negedge osc);
      for (int i = 0; i < NI; i++) begin
         int k, a1, a2, a3, a4;
         bit eo, ea, ew, er;
         logic [7:0] ed;
         logic [21:0] ev, av;
         k = off[i]; a1 = TA[i]; a2 = a1 + TH[i]; a3 = a2 + TS[i]; a4 = a3 + TP[i];
         eo = 0; ea = 0; ew = 1; er = 1; ed = 8'h00;
         if (active[i]) begin
            if (k < a1) begin
               ea = 1; eo = 1; ed = cur_a[i];
            end else if (k < a2) begin
               eo = 1; ed = cur_a[i];
            end else begin
               eo = cur_w[i];
               ed = cur_w[i] ? cur_d[i] : 8'h00;
               if (k >= a3 && k < a4) begin
                  ew = !cur_w[i]; er = cur_w[i];
               end
            end
         end
         ev = {armed[i] && !active[i], rsp_flag[i], rsp_rd[i], eo, ea, ew, er, ed};
         av = {req_ready[i], rsp_valid[i], rsp_rdata[i], bus_data_oe[i], bus_ale[i],
               bus_write_n[i], bus_read_n[i], (rst_n && !eo) ? 8'h00 : bus_data_o[i]};
         checks++;
         if (av !== ev) begin
            errors++;
            $display("FAIL outputs inst%0d cyc %0d: got %h want %h (rdy,rspv,rdata,oe,ale,wn,rn,data)",
                     i, cyc, av, ev);
         end
         if (rsp_valid[i] === 1'b1) begin
            rsp_cyc[i].push_back(cyc);
            rsp_dat[i].push_back(rsp_rdata[i]);
         end
         if (bus_ale[i] === 1'b1) ale_cnt[i]++;
         if (bus_write_n[i] === 1'b0) wn_cnt[i]++;
         if (bus_read_n[i] === 1'b0) rn_cnt[i]++;
      end
   end

   task automatic issue(input int i, input bit w, input logic [7:0] a, input logic [7:0] d);
      bit done;
      done = 0;
      req_valid[i] = 1'b1; req_write[i] = w; req_addr[i] = a; req_wdata[i] = d;
      for (int n = 0; n < 40 && !done; n++) begin
         @(posedge osc); #2;
         if (hs_now[i]) done = 1;
      end
      req_valid[i] = 1'b0;
      if (!done) check($sformatf("handshake_timeout_inst%0d", i), 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input int i);
      bit done;
      done = 0;
      for (int n = 0; n < 60 && !done; n++) begin
         @(negedge osc); #1;
         if (!active[i]) done = 1;
      end
      if (!done) check($sformatf("idle_timeout_inst%0d", i), 32'd0, 32'd1);
   endtask

   task automatic rand_run(input int i, input int n);
      for (int k = 0; k < n; k++) begin
         logic [7:0] a;
         int gap;
         a = 8'($urandom);
         if ($urandom_range(0, 3) != 0) a[4] = 1'b1;
         issue(i, 1'($urandom_range(0, 1)), a, 8'($urandom));
         gap = int'($urandom_range(0, 2));
         repeat (gap) begin
            @(posedge osc); #2;
         end
      end
      wait_idle(i);
   endtask

   initial begin
      int rb, hb;
      bit done;
      for (int i = 0; i < NI; i++) begin
         req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = 8'h00; req_wdata[i] = 8'h00;
         ale_cnt[i] = 0; wn_cnt[i] = 0; rn_cnt[i] = 0;
         for (int a = 0; a < 256; a++) mm[i][a] = 8'($urandom);
         mm[i][8'h13] = 8'hC3;
         mm[i][8'hFD] = 8'h34;
         mm[i][8'hFE] = 8'h12;
         mm[i][8'hFF] = 8'h05;
      end
      #1 rst_n = 1'b0;
      repeat (3) @(negedge osc);
      #2 rst_n = 1'b1;
      @(posedge osc); #2;

      // write 0x5A to 0x12, default timing
      rb = rsp_dat[0].size(); hb = hs_cyc[0].size();
      issue(0, 1'b1, 8'h12, 8'h5A);
      wait_idle(0);
      check("wr_latency", 32'(rsp_cyc[0][rb] - hs_cyc[0][hb]), 32'd8);
      check("wr_rdata", 32'(rsp_dat[0][rb]), 32'h00);
      check("wr_ale_cycles", 32'(ale_cnt[0]), 32'd2);
      check("wr_strobe_cycles", 32'(wn_cnt[0]), 32'd3);
      check("wr_target_latch", 32'(tgt[0].tmem[8'h12]), 32'h5A);

      // read 0x13
      rb = rsp_dat[0].size();
      issue(0, 1'b0, 8'h13, 8'h00);
      wait_idle(0);
      check("rd_data", 32'(rsp_dat[0][rb]), 32'hC3);
      check("rd_strobe_cycles", 32'(rn_cnt[0]), 32'd3);

      // ID registers back-to-back
      rb = rsp_dat[0].size(); hb = hs_cyc[0].size();
      issue(0, 1'b0, 8'hFD, 8'h00);
      issue(0, 1'b0, 8'hFE, 8'h00);
      issue(0, 1'b0, 8'hFF, 8'h00);
      wait_idle(0);
      check("id_major_lo", 32'(rsp_dat[0][rb]), 32'h34);
      check("id_major_hi", 32'(rsp_dat[0][rb+1]), 32'h12);
      check("id_minor", 32'(rsp_dat[0][rb+2]), 32'h05);
      check("id_b2b_1", 32'(hs_cyc[0][hb+1]), 32'(rsp_cyc[0][rb] + 1));
      check("id_b2b_2", 32'(hs_cyc[0][hb+2]), 32'(rsp_cyc[0][rb+1] + 1));

      // address OK bit clear: bus floats at zero
      rb = rsp_dat[0].size();
      issue(0, 1'b0, 8'h03, 8'h00);
      wait_idle(0);
      check("rd_no_addr_ok", 32'(rsp_dat[0][rb]), 32'h00);

      // all-ones timing
      rb = rsp_dat[1].size(); hb = hs_cyc[1].size();
      issue(1, 1'b1, 8'h12, 8'h5A);
      wait_idle(1);
      check("fast_latency", 32'(rsp_cyc[1][rb] - hs_cyc[1][hb]), 32'd5);
      check("fast_ale_cycles", 32'(ale_cnt[1]), 32'd1);
      check("fast_strobe_cycles", 32'(wn_cnt[1]), 32'd1);
      issue(1, 1'b0, 8'h12, 8'h00);
      wait_idle(1);
      check("fast_rd_data", 32'(rsp_dat[1][rb+1]), 32'h5A);
      check("fast_rd_strobe_cycles", 32'(rn_cnt[1]), 32'd1);

      fork
         rand_run(0, 40);
         rand_run(1, 40);
      join

      // reset in the second strobe cycle of a write
      rb = rsp_dat[0].size();
      issue(0, 1'b1, 8'h50, 8'hA7);
      done = 0;
      for (int n = 0; n < 30 && !done; n++) begin
         @(negedge osc); #1;
         if (active[0] && off[0] == TA[0] + TH[0] + TS[0] + 1) done = 1;
      end
      check("abort_reached_strobe", 32'(done), 32'd1);
      check("abort_strobe_low", 32'(bus_write_n[0]), 32'd0);
      #1 rst_n = 1'b0;
      #1;
      check("abort_write_n", 32'(bus_write_n[0]), 32'd1);
      check("abort_oe", 32'(bus_data_oe[0]), 32'd0);
      check("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      repeat (2) @(negedge osc);
      #2 rst_n = 1'b1;
      #1 check("ready_before_edge", 32'(req_ready[0]), 32'd0);
      @(posedge osc);
      #1 check("ready_after_edge", 32'(req_ready[0]), 32'd1);
      check("abort_no_rsp", 32'(rsp_dat[0].size()), 32'(rb));
      #1;
      issue(0, 1'b0, 8'h13, 8'h00);
      wait_idle(0);
      check("post_reset_rd", 32'(rsp_dat[0][rb]), 32'hC3);

      repeat (2) @(negedge osc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
